// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and helpers for the square-root datapath blocks.
//   recon_state_t   - IDLE / BUSY / DONE states of the radicand reconstructor
//   SQRT_DW_DEFAULT - default radicand width
//   recon_cnt_w()   - width of the partial-product step counter for a QW-bit root
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } recon_state_t;

  localparam int SQRT_DW_DEFAULT = 16;

  // The counter must hold 0..qw-1; a 1-bit minimum keeps tiny roots legal.
  function automatic int recon_cnt_w(input int qw);
    return (qw <= 2) ? 1 : $clog2(qw);
  endfunction

endpackage

// File: rtl/sqrt_recon_step.sv
// sqrt_recon_step: one shift-add step of the reconstruction squarer.
// Purely combinational; this is the only adder in sqrt_recon.
// Ports:
//   acc     in  [DW:0]   running accumulator
//   mcand   in  [QW-1:0] multiplicand (the root)
//   mbit    in  1        current multiplier LSB
//   i       in  [CW-1:0] step index, the shift applied to mcand
//   acc_nxt out [DW:0]   accumulator after this step
module sqrt_recon_step #(
  parameter int DW = 16,
  parameter int QW = 8,
  parameter int CW = 3
) (
  input  logic [DW:0]   acc,
  input  logic [QW-1:0] mcand,
  input  logic          mbit,
  input  logic [CW-1:0] i,
  output logic [DW:0]   acc_nxt
);

  logic [DW:0] pp;

  // Widen before shifting so the top partial product (shift QW-1) is not lost.
  assign pp      = (DW+1)'(mcand) << i;
  assign acc_nxt = mbit ? (acc + pp) : acc;

endmodule

// File: rtl/sqrt_recon.sv
// sqrt_recon: iterative radicand reconstructor, D = Q*Q + R.
// Takes a root/remainder pair from the sqrt block and rebuilds the radicand
// with a shift-add squarer, one partial product per clock (QW steps), and
// flags remainders a legal square root cannot produce (R > 2Q).
//
// Optional feature (macro SQRT_RECON_CHECK_EN): adds input D_ref, latched with
// the operands, and output match = result equals D_ref and the pair is legal.
//
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       synchronous active-high reset
//   start      in  1       request, sampled only in IDLE
//   Q          in  QW      root operand
//   remainder  in  RW      remainder operand
//   D          out DW      reconstructed radicand (held until next result)
//   busy       out 1       high while partial products are being added
//   ready      out 1       one-cycle pulse when D/invalid are updated
//   invalid    out 1       remainder > 2*Q, or the sum overflowed DW bits
//   D_ref      in  DW      (SQRT_RECON_CHECK_EN) expected radicand
//   match      out 1       (SQRT_RECON_CHECK_EN) D == D_ref on a legal pair
module sqrt_recon
  import sqrt_pkg::*;
#(
  parameter  int DW = SQRT_DW_DEFAULT,
  localparam int QW = DW / 2,
  localparam int RW = QW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [QW-1:0] Q,
  input  logic [RW-1:0] remainder,
`ifdef SQRT_RECON_CHECK_EN
  input  logic [DW-1:0] D_ref,
  output logic          match,
`endif
  output logic [DW-1:0] D,
  output logic          busy,
  output logic          ready,
  output logic          invalid
);

  localparam int            CW     = recon_cnt_w(QW);
  localparam logic [CW-1:0] I_LAST = CW'(QW - 1);

  recon_state_t  state, state_nxt;
  logic [QW-1:0] mcand;
  logic [QW-1:0] mplier;
  logic [DW:0]   acc;
  logic [DW:0]   acc_nxt;
  logic [CW-1:0] i;
  logic          invalid_r;
`ifdef SQRT_RECON_CHECK_EN
  logic [DW-1:0] dref_r;
`endif

  sqrt_recon_step #(
    .DW (DW),
    .QW (QW),
    .CW (CW)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .mbit    (mplier[0]),
    .i       (i),
    .acc_nxt (acc_nxt)
  );

  assign busy = (state == BUSY);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (i == I_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      i         <= '0;
      invalid_r <= 1'b0;
      D         <= '0;
      ready     <= 1'b0;
      invalid   <= 1'b0;
`ifdef SQRT_RECON_CHECK_EN
      dref_r    <= '0;
      match     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ready <= 1'b0;
      case (state)
        // Operand capture: acc starts at R so the squarer lands on Q*Q + R.
        IDLE: begin
          if (start) begin
            mcand     <= Q;
            mplier    <= Q;
            acc       <= (DW+1)'(remainder);
            i         <= '0;
            invalid_r <= (remainder > {Q, 1'b0});
`ifdef SQRT_RECON_CHECK_EN
            dref_r    <= D_ref;
`endif
          end
        end
        // Shift-add: always QW steps, even for Q=0, so latency is fixed.
        BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          i      <= i + 1'b1;
        end
        // Result: a carry into acc[DW] only happens for illegal pairs.
        DONE: begin
          D       <= acc[DW-1:0];
          invalid <= invalid_r | acc[DW];
          ready   <= 1'b1;
`ifdef SQRT_RECON_CHECK_EN
          match   <= (acc[DW-1:0] == dref_r) & ~invalid_r & ~acc[DW];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_recon.sv
// tb_sqrt_recon: self-checking bench for sqrt_recon with a timeline-level
// reference model (operation accepted -> busy for QW cycles -> result pulse),
// directed literal cases and randomized traffic including resets.
module tb_sqrt_recon;

  localparam int DW = 16;
  localparam int QW = DW / 2;
  localparam int RW = QW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [QW-1:0] Q;
  logic [RW-1:0] remainder;
  logic [DW-1:0] d_ref;
  logic [DW-1:0] D;
  logic          busy;
  logic          ready;
  logic          invalid;
  logic          match;

  int vectors   = 0;
  int miscompar = 0;

  always #5 clk = ~clk;

  sqrt_recon #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Q         (Q),
    .remainder (remainder),
`ifdef SQRT_RECON_CHECK_EN
    .D_ref     (d_ref),
    .match     (match),
`endif
    .D         (D),
    .busy      (busy),
    .ready     (ready),
    .invalid   (invalid)
  );

`ifndef SQRT_RECON_CHECK_EN
  assign match = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompar++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies QW busy cycles plus one
  // finishing cycle; the result appears (with ready) one edge later.
  int              m_t = -1;
  bit              model_on = 1'b0;
  logic [QW-1:0]   m_q;
  logic [RW-1:0]   m_r;
  logic [DW-1:0]   m_dref;
  logic [DW-1:0]   exp_D;
  logic            exp_inv, exp_ready, exp_match;

  always @(posedge clk) begin
    int sum;
    if (reset) begin
      m_t = -1; exp_D = '0; exp_inv = 0; exp_ready = 0; exp_match = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_ready = 0;
      if (m_t < 0) begin
        if (start) begin
          m_q = Q; m_r = remainder; m_dref = d_ref; m_t = 0;
        end
      end else if (m_t == QW) begin
        sum       = int'(m_q) * int'(m_q) + int'(m_r);
        exp_D     = sum[DW-1:0];
        exp_inv   = (int'(m_r) > 2 * int'(m_q)) || (sum >= (1 << DW));
        exp_match = (exp_D == m_dref) && !exp_inv;
        exp_ready = 1;
        m_t       = -1;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",    busy,    (m_t >= 0 && m_t < QW));
      chk("ready",   ready,   exp_ready);
      chk("D",       D,       exp_D);
      chk("invalid", invalid, exp_inv);
`ifdef SQRT_RECON_CHECK_EN
      chk("match",   match,   exp_match);
`endif
    end
  end

  task automatic do_op(input int q, input int r, input int dref,
                       input int eD, input int eInv, input int eMatch,
                       input string tag);
    int n, nb;
    @(negedge clk);
    Q = QW'(q); remainder = RW'(r); d_ref = DW'(dref); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; nb = int'(busy);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end
    if (!ready) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_latency"}, n, QW + 1);
    chk({tag, "_busycyc"}, nb, QW);
    chk({tag, "_D"}, D, eD);
    chk({tag, "_inv"}, invalid, eInv);
`ifdef SQRT_RECON_CHECK_EN
    chk({tag, "_match"}, match, eMatch);
`else
    if (eMatch < 0) chk({tag, "_match_arg"}, eMatch, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrdy, k1, k2;
    logic [DW-1:0] d1, d2;
    reset = 1'b1; start = 1'b0; Q = '0; remainder = '0; d_ref = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_D", D, 0);
    chk("rst_inv", invalid, 0);
    reset = 1'b0;

    do_op(0,   0,   0,     0,     0, 1, "q0r0");
    do_op(12,  7,   151,   151,   0, 1, "q12r7");
    do_op(255, 510, 65535, 65535, 0, 1, "fullscale");
    do_op(3,   7,   16,    16,    1, 0, "q3r7");
    do_op(255, 511, 0,     0,     1, 0, "overflow");
`ifdef SQRT_RECON_CHECK_EN
    do_op(12,  7,   150,   151,   0, 0, "dref_miss");
`endif

    // start held high: back-to-back operations, Q changed mid-operation
    @(negedge clk);
    Q = 8'd12; remainder = 9'd7; start = 1'b1;
    nrdy = 0; k1 = 0; k2 = 0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) Q = 8'd5;
      if (ready) begin
        nrdy++;
        if (nrdy == 1) begin d1 = D; k1 = k; end
        else begin d2 = D; k2 = k; end
      end
    end
    start = 1'b0;
    chk("held_nready", nrdy, 2);
    chk("held_D1", d1, 151);
    chk("held_D2", d2, 32);
    chk("held_period", k2 - k1, QW + 2);

    // reset in the 4th busy cycle
    @(negedge clk);
    Q = 8'd7; remainder = 9'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_D", D, 0);
    chk("midrst_ready", ready, 0);
    nrdy = 0;
    repeat (15) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("midrst_noready", nrdy, 0);
    do_op(9, 0, 81, 81, 0, 1, "q9r0");

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      int q;
      @(negedge clk);
      q         = int'($urandom_range(0, 255));
      Q         = QW'(q);
      remainder = ($urandom % 2 == 0) ? RW'($urandom_range(0, 2 * q)) : RW'($urandom % 512);
      d_ref     = ($urandom % 2 == 0) ? DW'(q * q + int'(remainder)) : DW'($urandom);
      start     = ($urandom % 4 != 0);
      reset     = ($urandom % 300 == 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (QW + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompar);
    $finish;
  end

endmodule
